instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mem_addr  output  16  address to instruction memory, sampled by the memory on every rising edge.
REQ-005 mem_data  input  16  instruction memory read data, valid in the cycle after the edge that sampled mem_addr.
REQ-006 instr  output  16  fetched instruction presented to decode.
REQ-007 instr_pc  output  16  address of instr.
REQ-008 instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-009 instr_ready  input  1  decode accepts the entry; transfer when instr_valid and instr_ready are both high at a rising edge.
REQ-010 redirect  input  1  branch/jump; sampled at rising edge.
REQ-011 redirect_pc  input  16  new fetch address, used when redirect is high.

Function
REQ-012 The block SHALL hold a 16-bit pc register and drive mem_addr = pc combinationally.
REQ-013 An issue SHALL occur at a rising edge when (entries buffered + in-flight - pop this edge) < buffer depth and redirect is low; on issue, pc <= pc + 1, and the issued pc is recorded with the in-flight flag set.
REQ-014 pc increment SHALL wrap 16'hFFFF -> 16'h0000.
REQ-015 When not issuing, pc SHALL hold; the repeated memory read of the same address is ignored.
REQ-016 At the edge after an issue, mem_data and the recorded pc SHALL be pushed into the buffer unless squashed.
REQ-017 The buffer SHALL be FIFO-ordered; instr/instr_pc/instr_valid SHALL reflect the head entry.
REQ-018 While instr_valid high and instr_ready low, instr and instr_pc SHALL remain stable.
REQ-019 Push and pop at the same edge SHALL both take effect; no entry is lost or duplicated.
REQ-020 redirect SHALL have priority over push, pop and issue: at that edge pc <= redirect_pc, buffer emptied, in-flight response squashed, no pop counted.
REQ-021 After a redirect edge, instr_valid SHALL be low for the following two cycles, and the first valid instr_pc SHALL equal redirect_pc.
REQ-022 A redirect in consecutive cycles SHALL leave only the last redirect_pc in effect.
REQ-023 First instr_valid after reset release SHALL assert after the second rising edge, with instr_pc = RESET_PC.

Reset
REQ-024 While reset_n is low: pc = RESET_PC, buffer empty, in-flight flag clear, instr_valid = 0, instr = 16'h0000, instr_pc = 16'h0000, mem_addr = RESET_PC.
REQ-025 Reset assertion SHALL take effect immediately, independent of clock, including mid-transfer; any in-flight response is discarded.

Configuration
REQ-026 Macro IFETCH_SKID_EN defined: buffer depth 2; with instr_ready held high, one instruction transfers per cycle.
REQ-027 IFETCH_SKID_EN undefined: buffer depth 1; at most one entry buffered or in flight, giving one transfer per two cycles.
REQ-028 Ordering, redirect and reset behaviour SHALL be identical in both configurations.

Verification
REQ-029 Bench memory model SHALL register mem_addr on the rising edge and return data equal to the address.
REQ-030 Reset, RESET_PC=0, instr_ready=1, skid on -> instr_valid high after 2nd edge; instr_pc/instr = 0,1,2,3 on consecutive cycles.
REQ-031 instr_ready low 3 cycles while instr_pc=5 -> instr=5 held; then 6,7 with no gap or duplicate.
REQ-032 redirect with redirect_pc=170 while an entry is valid and one is in flight -> valid low 2 cycles, next instr_pc=170, instr=170, no stale entry.
REQ-033 redirect_pc=16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000.
REQ-034 reset_n low mid-stream at instr_pc=9 -> instr_valid=0 and instr=0 immediately; after release, sequence restarts at RESET_PC.
REQ-035 IFETCH_SKID_EN undefined, instr_ready=1 -> instr_pc 0, 1, 2 valid on every second cycle.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: pc generator plus a small response buffer in front of decode.
// Define IFETCH_SKID_EN for a 2-entry buffer (one transfer per cycle); default is 1 entry.
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
);

`ifdef IFETCH_SKID_EN
   localparam logic [2:0] DEPTH = 3'd2;
`else
   localparam logic [2:0] DEPTH = 3'd1;
`endif

   logic [15:0] r_pc;
   logic [15:0] r_flight_pc;
   logic        r_flight;
   logic [1:0]  r_count;
   logic [15:0] r_buf_data [2];
   logic [15:0] r_buf_pc   [2];

   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic        w_wr_sel;
   logic [2:0]  w_occupancy;

   assign mem_addr    = r_pc;
   assign instr_valid = (r_count != 2'd0);
   assign instr       = r_buf_data[0];
   assign instr_pc    = r_buf_pc[0];

   assign w_pop       = instr_valid & instr_ready & ~redirect;
   assign w_push      = r_flight;
   // entries that will still be owed to decode after this edge, counting the outstanding read
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_flight} - {2'b00, w_pop};
   assign w_issue     = ~redirect & (w_occupancy < DEPTH);
   // write slot is the first free entry after any pop at the same edge
   assign w_wr_sel    = r_count[0] ^ w_pop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc          <= RESET_PC;
         r_flight      <= 1'b0;
         r_flight_pc   <= 16'h0000;
         r_count       <= 2'd0;
         r_buf_data[0] <= 16'h0000;
         r_buf_data[1] <= 16'h0000;
         r_buf_pc[0]   <= 16'h0000;
         r_buf_pc[1]   <= 16'h0000;
      end else if (redirect) begin
         r_pc     <= redirect_pc;
         r_flight <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         r_flight <= w_issue;
         if (w_issue) begin
            r_pc        <= r_pc + 16'd1;
            r_flight_pc <= r_pc;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop) begin
            r_buf_data[0] <= r_buf_data[1];
            r_buf_pc[0]   <= r_buf_pc[1];
         end
         if (w_push) begin
            r_buf_data[w_wr_sel] <= mem_data;
            r_buf_pc[w_wr_sel]   <= r_flight_pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, redirect/reset sequences and a
// randomized run against a transfer-level reference model. Follows IFETCH_SKID_EN.
module tb_instruction_fetch;

   localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef IFETCH_SKID_EN
   localparam int GAP = 0;
`else
   localparam int GAP = 1;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_pc;
   } vec_t;
   vec_t vecs[$];

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clock = ~clock;

   // memory returns its registered address as data
   logic [15:0] r_mem_q = 16'h0000;
   always @(posedge clock) r_mem_q <= mem_addr;
   assign mem_data = r_mem_q;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic add_vec(input logic r, input logic v, input logic [15:0] pc);
      vec_t e;
      e.ready = r;
      e.exp_valid = v;
      e.exp_pc = pc;
      vecs.push_back(e);
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_pc = 16'h0000;
      #2;
      chk("rst_valid", {15'b0, instr_valid}, 16'd0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
      chk("rst_mem_addr", mem_addr, RESET_PC);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic expect_entry(input string name, input logic [15:0] pc);
      chk({name, "_valid"}, {15'b0, instr_valid}, 16'd1);
      chk({name, "_pc"}, instr_pc, pc);
      chk({name, "_instr"}, instr, pc);
   endtask

   task automatic redirect_to(input logic [15:0] rpc, input int n);
      redirect = 1'b1;
      redirect_pc = rpc;
      tick;
      chk("redir_blank1", {15'b0, instr_valid}, 16'd0);
      redirect = 1'b0;
      tick;
      chk("redir_blank2", {15'b0, instr_valid}, 16'd0);
      for (int j = 0; j < n; j++) begin
         if (j > 0 && GAP == 1) begin
            tick;
            chk("redir_gap", {15'b0, instr_valid}, 16'd0);
         end
         tick;
         expect_entry("redir_seq", rpc + 16'(j));
      end
   endtask

   initial begin
      logic        found;
      logic        cur;
      int          wl;
      logic [15:0] exp_pc;

      reset_n = 1'b0;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_pc = 16'h0000;

      // row k: ready applied at edge k+1, outputs expected just after it
`ifdef IFETCH_SKID_EN
      add_vec(1'b1, 1'b0, 16'd0);
      for (int k = 1; k <= 6; k++) add_vec(1'b1, 1'b1, 16'(k - 1));
      for (int k = 0; k < 3; k++) add_vec(1'b0, 1'b1, 16'd5);
      add_vec(1'b1, 1'b1, 16'd6);
      add_vec(1'b1, 1'b1, 16'd7);
      add_vec(1'b1, 1'b1, 16'd8);
`else
      for (int k = 0; k <= 5; k++) begin
         add_vec(1'b1, 1'b0, 16'd0);
         add_vec(1'b1, 1'b1, 16'(k));
      end
      for (int k = 0; k < 3; k++) add_vec(1'b0, 1'b1, 16'd5);
      add_vec(1'b1, 1'b0, 16'd0);
      add_vec(1'b1, 1'b1, 16'd6);
      add_vec(1'b1, 1'b0, 16'd0);
      add_vec(1'b1, 1'b1, 16'd7);
`endif

      do_reset;
      foreach (vecs[i]) begin
         instr_ready = vecs[i].ready;
         tick;
         chk($sformatf("vec%0d_valid", i), {15'b0, instr_valid}, {15'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_pc);
         end
      end

      instr_ready = 1'b1;
      redirect_to(16'd170, 3);
      redirect_to(16'hFFFE, 3);

      // back-to-back redirects: only the last target survives
      redirect = 1'b1;
      redirect_pc = 16'h1234;
      tick;
      chk("dbl_blank1", {15'b0, instr_valid}, 16'd0);
      redirect_pc = 16'h4321;
      tick;
      chk("dbl_blank2", {15'b0, instr_valid}, 16'd0);
      redirect = 1'b0;
      tick;
      chk("dbl_blank3", {15'b0, instr_valid}, 16'd0);
      tick;
      expect_entry("dbl_first", 16'h4321);

      // reset in the middle of the stream
      do_reset;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick;
         if (instr_valid && instr_pc == 16'd9) found = 1'b1;
      end
      chk("reach_pc9", {15'b0, found}, 16'd1);
      if (found) begin
         #2 reset_n = 1'b0;
         #1;
         chk("midrst_valid", {15'b0, instr_valid}, 16'd0);
         chk("midrst_instr", instr, 16'h0000);
         chk("midrst_instr_pc", instr_pc, 16'h0000);
         chk("midrst_mem_addr", mem_addr, RESET_PC);
         @(negedge clock);
         reset_n = 1'b1;
         tick;
         chk("midrst_blank", {15'b0, instr_valid}, 16'd0);
         tick;
         expect_entry("midrst_first", RESET_PC);
      end

      // randomized run: wl = invalid samples still due, exp_pc = next pc decode must see
      do_reset;
      wl = 1;
      exp_pc = RESET_PC;
      for (int c = 0; c < 3000; c++) begin
         tick;
         cur = (wl == 0);
         if (!cur) begin
            chk("rnd_blank", {15'b0, instr_valid}, 16'd0);
            wl--;
         end else begin
            expect_entry("rnd", exp_pc);
         end
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
         else
            redirect_pc = 16'($urandom);
         if (redirect) begin
            exp_pc = redirect_pc;
            wl = 2;
         end else if (cur && instr_ready) begin
            exp_pc = exp_pc + 16'd1;
            wl = GAP;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
